// File: rtl/sym_preadd_ctrl.sv
// Input controller for symmetric/antisymmetric FIR filters: a NUM_TAPS-deep sample window
// with registered pre-added tap pairs, centre tap, valid/ready handshake, priming and flush.
module sym_preadd_ctrl #(
  parameter int DATA_W   = 10,
  parameter int NUM_TAPS = 77,
  parameter int PRIME    = 1,
  localparam int NPAIR   = (NUM_TAPS - 1) / 2,
  localparam int PW      = DATA_W + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  mode_anti,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NPAIR*PW-1:0]   tapsum_bus,
  output logic [DATA_W-1:0]     center_out,
  output logic                  out_anti
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(NUM_TAPS);

  logic [DATA_W-1:0]   d_q [NUM_TAPS];
  logic [DATA_W-1:0]   d_d [NUM_TAPS];
  logic [DATA_W-1:0]   win [NUM_TAPS];
  logic [NPAIR*PW-1:0] tapsum_q, tapsum_d, pair_bus;
  logic [DATA_W-1:0]   center_q, center_d;
  logic                anti_q, anti_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    fill_q, fill_d, fill_inc;
  logic [PW-1:0]       op_a, op_b;
  logic                accept;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;

  // Window as it will look after this cycle's shift; the outputs are built from it.
  always_comb begin
    win[0] = in_data;
    for (int k = 1; k < NUM_TAPS; k++) begin
      win[k] = d_q[k-1];
    end
  end

  // Operands are sign-extended by one bit so neither the sum nor the difference can wrap.
  always_comb begin
    pair_bus = '0;
    op_a     = '0;
    op_b     = '0;
    for (int i = 0; i < NPAIR; i++) begin
      op_a = {win[i][DATA_W-1], win[i]};
      op_b = {win[NUM_TAPS-1-i][DATA_W-1], win[NUM_TAPS-1-i]};
      pair_bus[i*PW +: PW] = mode_anti ? (op_a - op_b) : (op_a + op_b);
    end
  end

  // NOTE: every variable gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    d_d      = d_q;
    tapsum_d = tapsum_q;
    center_d = center_q;
    anti_d   = anti_q;
    valid_d  = valid_q;
    fill_d   = fill_q;
    if (flush) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        d_d[k] = '0;
      end
      tapsum_d = '0;
      center_d = '0;
      anti_d   = 1'b0;
      valid_d  = 1'b0;
      fill_d   = '0;
    end else if (accept) begin
      d_d      = win;
      tapsum_d = pair_bus;
      center_d = win[NPAIR];
      anti_d   = mode_anti;
      fill_d   = fill_inc;
      valid_d  = (PRIME != 0) ? (fill_inc == FILL_FULL) : 1'b1;
    end else if (out_ready) begin
      valid_d  = 1'b0;
    end
  end

  // NOTE: the delay line is a real reset target here (cleared window is observable), so
  // every element is reset rather than left to power-up contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        d_q[k] <= '0;
      end
      tapsum_q <= '0;
      center_q <= '0;
      anti_q   <= 1'b0;
      valid_q  <= 1'b0;
      fill_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      d_q      <= d_d;
      tapsum_q <= tapsum_d;
      center_q <= center_d;
      anti_q   <= anti_d;
      valid_q  <= valid_d;
      fill_q   <= fill_d;
    end
  end

  assign out_valid  = valid_q;
  assign tapsum_bus = tapsum_q;
  assign center_out = center_q;
  assign out_anti   = anti_q;

endmodule
